// File: rtl/memtest_bist_if.sv
// Control/status bundle for the memtest_bist engine: run request in,
// progress, verdict and read-back observation out.
interface memtest_bist_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              inject_err;
  logic              busy;
  logic              done;
  logic              pass_ok;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;

  modport master (
    output start, inject_err,
    input  busy, done, pass_ok, err_count, fail_addr, data_out, data_valid
  );

  modport slave (
    input  start, inject_err,
    output busy, done, pass_ok, err_count, fail_addr, data_out, data_valid
  );
endinterface

// File: rtl/memtest_bist.sv
// PRBS16 memory BIST: fills an internal DEPTH x DATA_W RAM, reads it back,
// checks every word on chip and accumulates mismatches over PASSES passes.
module memtest_bist #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 5,
  parameter int          PASSES = 4,
  parameter logic [15:0] SEED   = 16'hFFFF
) (
  input  logic           clk,
  input  logic           rst,
  memtest_bist_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int REP   = DATA_W / 16;
  localparam int PW    = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [ADDR_W:0] LAST_WR   = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LAST_RD   = (ADDR_W + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PASS = PW'(PASSES - 1);

  if (DATA_W % 16 != 0) begin : g_bad_width
    $error("memtest_bist: DATA_W must be a multiple of 16");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  function automatic logic [15:0] prbs_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [PW-1:0]     pass_q, pass_d;
  logic [15:0]       gen_q, gen_d;
  logic [15:0]       chk_q, chk_d;
  logic [15:0]       seed_q, seed_d;
  logic              inj_q, inj_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we, re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W:0]   prev_cnt;

  assign addr     = cnt_q[ADDR_W-1:0];
  assign prev_cnt = cnt_q - (ADDR_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    gen_d   = gen_q;
    chk_d   = chk_q;
    seed_d  = seed_q;
    inj_d   = inj_q;
    err_d   = err_q;
    fail_d  = fail_q;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = {REP{gen_q}};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = WRITE;
          cnt_d   = '0;
          pass_d  = '0;
          gen_d   = SEED;
          seed_d  = SEED;
          err_d   = '0;
          fail_d  = '0;
          inj_d   = bus.inject_err;
        end
      end

      WRITE: begin
        we    = 1'b1;
        gen_d = prbs_step(gen_q);
        // Fault-injection self-test: a single flipped bit, overwritten by pass 1
        if (inj_q && pass_q == '0 && cnt_q == '0) begin
          wdata[0] = ~wdata[0];
        end
        if (cnt_q == LAST_WR) begin
          state_d = READ;
          cnt_d   = '0;
          chk_d   = seed_q;
        end else begin
          cnt_d = cnt_q + (ADDR_W + 1)'(1);
        end
      end

      READ: begin
        re = (cnt_q != LAST_RD);
        // rdata_q holds word cnt-1, issued on the previous cycle
        if (cnt_q != '0) begin
          chk_d = prbs_step(chk_q);
          if (rdata_q != {REP{chk_q}}) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) begin
              fail_d = prev_cnt[ADDR_W-1:0];
            end
          end
        end
        if (cnt_q == LAST_RD) begin
          cnt_d  = '0;
          seed_d = gen_q;
          if (pass_q == LAST_PASS) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
            pass_d  = pass_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q + (ADDR_W + 1)'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      gen_q   <= '0;
      chk_q   <= '0;
      seed_q  <= '0;
      inj_q   <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      gen_q   <= gen_d;
      chk_q   <= chk_d;
      seed_q  <= seed_d;
      inj_q   <= inj_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // RAM array itself is never cleared; only its read register is
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign bus.busy       = (state_q == WRITE) || (state_q == READ);
  assign bus.done       = (state_q == DONE);
  assign bus.pass_ok    = (state_q == DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_addr  = fail_q;
  assign bus.data_out   = rdata_q;
  assign bus.data_valid = (state_q == READ) && (cnt_q != '0);

endmodule

// File: tb/tb_memtest_bist.sv
// Directed bench for memtest_bist: default instance plus a 64-bit, 8-deep,
// 2-pass instance running side by side on one clock and reset.
module tb_memtest_bist;

  logic clk;
  logic rst;

  memtest_bist_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  memtest_bist_if #(.DATA_W(64), .ADDR_W(3)) bus2 ();

  memtest_bist u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  memtest_bist #(.DATA_W(64), .ADDR_W(3), .PASSES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] prbs(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] m1, m2;
  int          n1, n2;
  logic [31:0] w1 [3];
  logic [63:0] w2_first;

  initial begin
    rst = 1'b0;
    bus1.start = 1'b0; bus1.inject_err = 1'b0;
    bus2.start = 1'b0; bus2.inject_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_busy",  64'(bus1.busy), 64'd0);
    check("rst_done",  64'(bus1.done), 64'd0);
    check("rst_ok",    64'(bus1.pass_ok), 64'd0);
    check("rst_err",   64'(bus1.err_count), 64'd0);
    check("rst_fail",  64'(bus1.fail_addr), 64'd0);
    check("rst_dv",    64'(bus1.data_valid), 64'd0);
    check("rst_dout",  64'(bus1.data_out), 64'd0);
    check("rst_done2", 64'(bus2.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Clean run on both instances with full data-stream checking
    bus1.start = 1'b1; bus2.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus2.start = 1'b0;
    check("t1_busy1", 64'(bus1.busy), 64'd1);
    check("t1_busy2", 64'(bus2.busy), 64'd1);
    m1 = 16'hFFFF; m2 = 16'hFFFF; n1 = 0; n2 = 0;
    w2_first = '0;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus1.data_valid) begin
        if (n1 < 3) w1[n1] = bus1.data_out;
        check("word1", 64'(bus1.data_out), 64'({2{m1}}));
        m1 = prbs(m1);
        n1++;
      end
      if (bus2.data_valid) begin
        if (n2 == 0) w2_first = bus2.data_out;
        check("word2", bus2.data_out, {4{m2}});
        m2 = prbs(m2);
        n2++;
      end
      if (cyc == 34) check("t6_done_early", 64'(bus2.done), 64'd0);
      if (cyc == 35) begin
        check("t6_done",  64'(bus2.done), 64'd1);
        check("t6_ok",    64'(bus2.pass_ok), 64'd1);
        check("t6_err",   64'(bus2.err_count), 64'd0);
      end
    end
    check("t1_done_early", 64'(bus1.done), 64'd0);
    @(negedge clk);
    check("t1_done",  64'(bus1.done), 64'd1);
    check("t1_ok",    64'(bus1.pass_ok), 64'd1);
    check("t1_err",   64'(bus1.err_count), 64'd0);
    check("t1_fail",  64'(bus1.fail_addr), 64'd0);
    check("t1_busy",  64'(bus1.busy), 64'd0);
    check("t1_dv",    64'(bus1.data_valid), 64'd0);
    check("t2_n1",    64'(n1), 64'd128);
    check("t2_w0",    64'(w1[0]), 64'hFFFFFFFF);
    check("t2_w1",    64'(w1[1]), 64'hFFFEFFFE);
    check("t2_w2",    64'(w1[2]), 64'hFFFCFFFC);
    check("t6_n2",    64'(n2), 64'd16);
    check("t6_first", w2_first, 64'hFFFFFFFFFFFFFFFF);

    // Fault injection, launched from DONE
    bus1.start = 1'b1; bus1.inject_err = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.inject_err = 1'b0;
    check("t3_done_drop", 64'(bus1.done), 64'd0);
    check("t3_busy",      64'(bus1.busy), 64'd1);
    repeat (259) @(negedge clk);
    check("t3_done_early", 64'(bus1.done), 64'd0);
    @(negedge clk);
    check("t3_done", 64'(bus1.done), 64'd1);
    check("t3_err",  64'(bus1.err_count), 64'd1);
    check("t3_fail", 64'(bus1.fail_addr), 64'd0);
    check("t3_ok",   64'(bus1.pass_ok), 64'd0);

    // Start held high through a whole run, then relaunch from DONE
    bus1.start = 1'b1;
    @(negedge clk);
    check("t5_err_clr", 64'(bus1.err_count), 64'd0);
    check("t5_busy",    64'(bus1.busy), 64'd1);
    repeat (259) @(negedge clk);
    check("t5_busy_late", 64'(bus1.busy), 64'd1);
    check("t5_done_early", 64'(bus1.done), 64'd0);
    @(negedge clk);
    check("t5_done", 64'(bus1.done), 64'd1);
    check("t5_ok",   64'(bus1.pass_ok), 64'd1);
    @(negedge clk);
    bus1.start = 1'b0;
    check("t5_relaunch_done", 64'(bus1.done), 64'd0);
    check("t5_relaunch_busy", 64'(bus1.busy), 64'd1);
    repeat (259) @(negedge clk);
    check("t5_done2_early", 64'(bus1.done), 64'd0);
    @(negedge clk);
    check("t5_done2", 64'(bus1.done), 64'd1);
    check("t5_ok2",   64'(bus1.pass_ok), 64'd1);

    // Reset mid-READ of pass 2 while an injected error is already counted
    bus1.start = 1'b1; bus1.inject_err = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.inject_err = 1'b0;
    repeat (169) @(negedge clk);
    check("t4_err_pre", 64'(bus1.err_count), 64'd1);
    check("t4_dv_pre",  64'(bus1.data_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t4_busy",  64'(bus1.busy), 64'd0);
    check("t4_done",  64'(bus1.done), 64'd0);
    check("t4_err",   64'(bus1.err_count), 64'd0);
    check("t4_dv",    64'(bus1.data_valid), 64'd0);
    check("t4_fail",  64'(bus1.fail_addr), 64'd0);
    check("t4_done2", 64'(bus2.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    check("t4_rerun_busy", 64'(bus1.busy), 64'd1);
    repeat (259) @(negedge clk);
    check("t4_rerun_early", 64'(bus1.done), 64'd0);
    @(negedge clk);
    check("t4_rerun_done", 64'(bus1.done), 64'd1);
    check("t4_rerun_ok",   64'(bus1.pass_ok), 64'd1);
    check("t4_rerun_err",  64'(bus1.err_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
